mips_mc_ctrl: RTL and testbench
===============================

# mips_mc_ctrl

Multi-cycle sequencing controller for the MIPS datapath. It replaces single-cycle decoding with a registered FSM that steps each instruction through fetch, decode, execute, memory and writeback. It drives the shared instruction/data memory port with a ready handshake and generates PC, IR, ALU, register-file and memory controls per state. It sits between the IR register (source of op/funct) and the datapath muxes and enables.

## Interface
- MEM_TIMEOUT, default 15: maximum number of wait cycles on a memory request; 0 disables the timeout.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- op  in  6  opcode from the IR register.
- funct  in  6  function field from the IR register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory has completed the current request.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write (SW only).
- mem_addr_sel  out  1  memory address source: 0 = PC, 1 = ALUOut.
- ir_wr  out  1  IR load enable.
- pc_wr  out  1  PC load enable.
- pc_src  out  2  PC source: 00 = PC+4, 01 = branch target, 10 = jump target.
- alu_ctrl  out  5  ALU operation code.
- alu_src_a, alu_src_b, reg_dst, mem2reg  out  2 each  datapath mux selects.
- ext  out  1  immediate extension: 1 = sign, 0 = zero.
- reg_wr  out  1  register-file write enable.
- state  out  3  current FSM state, for debug.
- illegal  out  1  sticky flag: undecodable instruction.
- timeout  out  1  sticky flag: memory timeout.

## Operation
- States:
  - IF = 0, ID = 1, EX = 2, MEM = 3, WB = 4, TRAP = 5.
  - State is a registered value. All outputs are combinational from the state, op/funct, zero and mem_ready.
- IF:
  - mem_req = 1, mem_addr_sel = 0.
  - On mem_ready: ir_wr = 1, pc_wr = 1, pc_src = 00, next state ID.
- ID:
  - J: pc_wr = 1, pc_src = 10, next state IF.
  - Any other legal instruction: next state EX.
  - Illegal instruction: see Configuration.
- EX: drives alu_ctrl, alu_src_a, alu_src_b and ext.
  - BEQ: pc_wr = zero, pc_src = 01, next state IF.
  - BNE: pc_wr = ~zero, pc_src = 01, next state IF.
  - LW/SW: next state MEM.
  - Others: next state WB.
  - The datapath registers ALUOut at the end of EX.
- MEM:
  - mem_req = 1, mem_addr_sel = 1, mem_we = (op == SW).
  - On mem_ready: SW goes to IF, LW goes to WB.
- WB:
  - reg_wr = 1; reg_dst and mem2reg per instruction.
  - Next state IF.
- Decode values:
  - R-type: reg_dst = 01. Shifts (SLL/SRL/SRA) use alu_src_b = 01; other R-type ops use 00. Immediate forms use alu_src_b = 10, reg_dst = 00.
  - ALU codes: add/addu/addiu/lw/sw 00000, sub/subu/beq/bne 00001, sll/lui 00010, srl 00011, slt/slti 00100, and/andi 00101, or/ori 00110, xor/xori 00111, sltu/sltiu 01000, sra 01001, nor 01010.
  - LUI: alu_src_a = 01.
  - LW: mem2reg = 01.
  - ext = 1 for SLTI, BEQ and BNE only.
- Legal set: the R-type functs above plus ADDIU, SLTI, SLTIU, ANDI, ORI, XORI, LUI, LW, SW, BEQ, BNE, J. Everything else is illegal.
- Timeout counter (width $clog2(MEM_TIMEOUT+1)):
  - Cleared on entering IF or MEM.
  - Increments each IF/MEM cycle with mem_ready = 0.
  - If mem_ready = 0 and count == MEM_TIMEOUT-1, the next state is TRAP and timeout is set.
- TRAP: all enables and requests are 0. The state holds until reset.

## Timing
- Reset: while rst_n = 0 at a clock edge, state becomes IF, flags clear and the counter clears. All outputs are 0 while rst_n is low.
  - The first cycle after release is IF with mem_req = 1.
- Zero-wait memory (mem_ready high in the request cycle) completes in that same cycle.
- mem_ready outside IF/MEM is ignored.
- Latency with zero-wait memory:
  - J: 2 cycles.
  - BEQ/BNE: 3 cycles.
  - R-type/immediate: 4 cycles.
  - SW: 4 cycles.
  - LW: 5 cycles.
- Each wait cycle adds 1 cycle.
- Reset asserted mid-instruction aborts it. No partial reg_wr or mem_we is issued in that cycle.

## Configuration
- MIPS_MC_ILLEGAL_TRAP_EN:
  - Defined: an illegal instruction in ID moves to TRAP and sets illegal.
  - Undefined: an illegal instruction is executed as a NOP; ID moves to IF and illegal stays 0.
  - The timeout TRAP exists in both builds.

## Structure
- Package mips_ctrl_pkg holds:
  - opcode and funct constants;
  - ALU code constants;
  - the state enum;
  - pc_src encodings.
- Sub-module mips_instr_decode: purely combinational. Maps op/funct to alu_ctrl, the mux selects, ext, a legal flag and an instruction class (alu, lw, sw, beq, bne, j).
- The FSM, handshake and counter live in mips_mc_ctrl.

## Test plan
- Reset: hold rst_n low for 3 cycles → all outputs 0 and state = 0. Release → mem_req = 1 and mem_addr_sel = 0 on the first cycle.
- ADDU, mem_ready held 1 → states IF, ID, EX, WB.
  - pc_wr and ir_wr high in IF only.
  - WB: reg_wr = 1, reg_dst = 01, alu_ctrl = 00000.
  - Back in IF at cycle 5.
- LW, mem_ready low for 2 MEM cycles →
  - MEM lasts 3 cycles with mem_we = 0 and mem_addr_sel = 1.
  - WB: mem2reg = 01, reg_wr = 1.
- BEQ with zero = 1 → EX: pc_wr = 1, pc_src = 01. BEQ with zero = 0 → pc_wr = 0. BNE → inverse of BEQ.
- op = 111111:
  - With the macro: TRAP (state = 5), illegal = 1, no further mem_req.
  - Without the macro: IF on the next cycle.
- MEM_TIMEOUT = 4, mem_ready held 0 in IF → 4 IF cycles, then TRAP with timeout = 1. A later mem_ready has no effect.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared constants and types for the multi-cycle MIPS controller:
// opcode/funct fields, ALU codes, FSM states, PC source selects and decode record.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2a;
    localparam logic [5:0] FN_SLTU = 6'h2b;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_SLL  = 5'd2;
    localparam logic [4:0] ALU_SRL  = 5'd3;
    localparam logic [4:0] ALU_SLT  = 5'd4;
    localparam logic [4:0] ALU_AND  = 5'd5;
    localparam logic [4:0] ALU_OR   = 5'd6;
    localparam logic [4:0] ALU_XOR  = 5'd7;
    localparam logic [4:0] ALU_SLTU = 5'd8;
    localparam logic [4:0] ALU_SRA  = 5'd9;
    localparam logic [4:0] ALU_NOR  = 5'd10;

    localparam logic [1:0] PC_SRC_SEQ = 2'b00;
    localparam logic [1:0] PC_SRC_BR  = 2'b01;
    localparam logic [1:0] PC_SRC_JMP = 2'b10;

    typedef enum logic [2:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EX   = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_TRAP = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        CLS_ALU = 3'd0,
        CLS_LW  = 3'd1,
        CLS_SW  = 3'd2,
        CLS_BEQ = 3'd3,
        CLS_BNE = 3'd4,
        CLS_J   = 3'd5
    } instr_cls_e;

    typedef struct packed {
        logic [4:0] alu_ctrl;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] reg_dst;
        logic [1:0] mem2reg;
        logic       ext;
        logic       legal;
        instr_cls_e cls;
    } dec_t;

endpackage

// File: rtl/mips_instr_decode.sv
// Combinational op/funct decoder: ALU code, mux selects, extension, legality and class.
module mips_instr_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    output dec_t       dec_o
);

    always_comb begin
        dec_o       = '0;
        dec_o.cls   = CLS_ALU;
        dec_o.legal = 1'b1;
        case (op_i)
            OP_RTYPE: begin
                dec_o.reg_dst = 2'b01;
                case (funct_i)
                    FN_ADD, FN_ADDU: dec_o.alu_ctrl = ALU_ADD;
                    FN_SUB, FN_SUBU: dec_o.alu_ctrl = ALU_SUB;
                    FN_SLL: begin dec_o.alu_ctrl = ALU_SLL; dec_o.alu_src_b = 2'b01; end
                    FN_SRL: begin dec_o.alu_ctrl = ALU_SRL; dec_o.alu_src_b = 2'b01; end
                    FN_SRA: begin dec_o.alu_ctrl = ALU_SRA; dec_o.alu_src_b = 2'b01; end
                    FN_AND:  dec_o.alu_ctrl = ALU_AND;
                    FN_OR:   dec_o.alu_ctrl = ALU_OR;
                    FN_XOR:  dec_o.alu_ctrl = ALU_XOR;
                    FN_NOR:  dec_o.alu_ctrl = ALU_NOR;
                    FN_SLT:  dec_o.alu_ctrl = ALU_SLT;
                    FN_SLTU: dec_o.alu_ctrl = ALU_SLTU;
                    default: dec_o.legal = 1'b0;
                endcase
            end
            OP_ADDIU: begin dec_o.alu_ctrl = ALU_ADD;  dec_o.alu_src_b = 2'b10; end
            OP_SLTI:  begin dec_o.alu_ctrl = ALU_SLT;  dec_o.alu_src_b = 2'b10; dec_o.ext = 1'b1; end
            OP_SLTIU: begin dec_o.alu_ctrl = ALU_SLTU; dec_o.alu_src_b = 2'b10; end
            OP_ANDI:  begin dec_o.alu_ctrl = ALU_AND;  dec_o.alu_src_b = 2'b10; end
            OP_ORI:   begin dec_o.alu_ctrl = ALU_OR;   dec_o.alu_src_b = 2'b10; end
            OP_XORI:  begin dec_o.alu_ctrl = ALU_XOR;  dec_o.alu_src_b = 2'b10; end
            OP_LUI: begin
                dec_o.alu_ctrl  = ALU_SLL;
                dec_o.alu_src_a = 2'b01;
                dec_o.alu_src_b = 2'b10;
            end
            OP_LW: begin
                dec_o.alu_ctrl  = ALU_ADD;
                dec_o.alu_src_b = 2'b10;
                dec_o.mem2reg   = 2'b01;
                dec_o.cls       = CLS_LW;
            end
            OP_SW: begin
                dec_o.alu_ctrl  = ALU_ADD;
                dec_o.alu_src_b = 2'b10;
                dec_o.cls       = CLS_SW;
            end
            OP_BEQ: begin dec_o.alu_ctrl = ALU_SUB; dec_o.ext = 1'b1; dec_o.cls = CLS_BEQ; end
            OP_BNE: begin dec_o.alu_ctrl = ALU_SUB; dec_o.ext = 1'b1; dec_o.cls = CLS_BNE; end
            OP_J:     dec_o.cls = CLS_J;
            default:  dec_o.legal = 1'b0;
        endcase
        // Illegal encodings collapse to an all-zero NOP so no stray selects leak out.
        if (!dec_o.legal) begin
            dec_o     = '0;
            dec_o.cls = CLS_ALU;
        end
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS sequencing FSM with memory handshake and timeout.
// Define MIPS_MC_ILLEGAL_TRAP_EN to trap on illegal instructions (default: execute as NOP).
module mips_mc_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       ir_wr,
    output logic       pc_wr,
    output logic [1:0] pc_src,
    output logic [4:0] alu_ctrl,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] reg_dst,
    output logic [1:0] mem2reg,
    output logic       ext,
    output logic       reg_wr,
    output logic [2:0] state,
    output logic       illegal,
    output logic       timeout
);

    localparam int unsigned CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    dec_t             dec;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             illegal_q, illegal_d;
    logic             timeout_q, timeout_d;
    logic             wait_expired;

    mips_instr_decode u_decode (
        .op_i    (op),
        .funct_i (funct),
        .dec_o   (dec)
    );

    assign wait_expired = (MEM_TIMEOUT != 0) && !mem_ready && (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IF;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        illegal_d    = illegal_q;
        timeout_d    = timeout_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_wr        = 1'b0;
        pc_wr        = 1'b0;
        pc_src       = PC_SRC_SEQ;
        alu_ctrl     = '0;
        alu_src_a    = '0;
        alu_src_b    = '0;
        reg_dst      = '0;
        mem2reg      = '0;
        ext          = 1'b0;
        reg_wr       = 1'b0;

        case (state_q)
            ST_IF: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_wr   = 1'b1;
                    pc_wr   = 1'b1;
                    state_d = ST_ID;
                end else if (wait_expired) begin
                    state_d   = ST_TRAP;
                    timeout_d = 1'b1;
                end
            end
            ST_ID: begin
                if (!dec.legal) begin
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
                    state_d   = ST_TRAP;
                    illegal_d = 1'b1;
`else
                    state_d   = ST_IF;
`endif
                end else if (dec.cls == CLS_J) begin
                    pc_wr   = 1'b1;
                    pc_src  = PC_SRC_JMP;
                    state_d = ST_IF;
                end else begin
                    state_d = ST_EX;
                end
            end
            ST_EX: begin
                alu_ctrl  = dec.alu_ctrl;
                alu_src_a = dec.alu_src_a;
                alu_src_b = dec.alu_src_b;
                ext       = dec.ext;
                case (dec.cls)
                    CLS_BEQ: begin pc_wr = zero;  pc_src = PC_SRC_BR; state_d = ST_IF; end
                    CLS_BNE: begin pc_wr = !zero; pc_src = PC_SRC_BR; state_d = ST_IF; end
                    CLS_LW, CLS_SW: state_d = ST_MEM;
                    default:        state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (dec.cls == CLS_SW);
                if (mem_ready) begin
                    state_d = (dec.cls == CLS_SW) ? ST_IF : ST_WB;
                end else if (wait_expired) begin
                    state_d   = ST_TRAP;
                    timeout_d = 1'b1;
                end
            end
            ST_WB: begin
                reg_wr  = 1'b1;
                reg_dst = dec.reg_dst;
                mem2reg = dec.mem2reg;
                state_d = ST_IF;
            end
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_IF;
        endcase

        // Any state change counts as "entering" IF/MEM; only waits within one state accumulate.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if ((state_q == ST_IF || state_q == ST_MEM) && !mem_ready) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end

        state   = state_q;
        illegal = illegal_q;
        timeout = timeout_q;
        // Outputs are forced quiet during reset so an aborted instruction issues nothing.
        if (!rst_n) begin
            mem_req      = 1'b0;
            mem_we       = 1'b0;
            mem_addr_sel = 1'b0;
            ir_wr        = 1'b0;
            pc_wr        = 1'b0;
            pc_src       = '0;
            alu_ctrl     = '0;
            alu_src_a    = '0;
            alu_src_b    = '0;
            reg_dst      = '0;
            mem2reg      = '0;
            ext          = 1'b0;
            reg_wr       = 1'b0;
            state        = '0;
            illegal      = 1'b0;
            timeout      = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed, table-driven check of mips_mc_ctrl with hand sequences for waits, reset, illegal and timeout.
module tb_mips_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] op = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       mem_req, mem_we, mem_addr_sel, ir_wr, pc_wr, ext, reg_wr, illegal, timeout;
    logic [1:0] pc_src, alu_src_a, alu_src_b, reg_dst, mem2reg;
    logic [4:0] alu_ctrl;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    mips_mc_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .op           (op),
        .funct        (funct),
        .zero         (zero),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_wr        (ir_wr),
        .pc_wr        (pc_wr),
        .pc_src       (pc_src),
        .alu_ctrl     (alu_ctrl),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .reg_dst      (reg_dst),
        .mem2reg      (mem2reg),
        .ext          (ext),
        .reg_wr       (reg_wr),
        .state        (state),
        .illegal      (illegal),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        int         lat;
        logic [4:0] alu;
        logic [1:0] srca;
        logic [1:0] srcb;
        logic [1:0] pcsrc;
        logic [1:0] rd;
        logic [1:0] m2r;
        logic       ext;
        logic       pcwr;
        logic       regwr;
        logic       memwe;
        logic       jmp;
    } vec_t;

    vec_t vecs[17];

    int         r_lat, r_nir, r_nmem;
    logic [4:0] r_alu;
    logic [1:0] r_srca, r_srcb, r_pcsrc, r_rd, r_m2r;
    logic       r_ext, r_pcwr, r_regwr, r_memwe, r_jmp, r_addr_ok;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {5'd0, mem_req, mem_we, mem_addr_sel, ir_wr, pc_wr, pc_src, alu_ctrl, alu_src_a,
                alu_src_b, reg_dst, mem2reg, ext, reg_wr, state, illegal, timeout};
    endfunction

    // Runs one instruction from an IF cycle back to the next IF, recording per-state outputs.
    task automatic run_instr(input int mem_waits);
        r_lat = 0; r_nir = 0; r_nmem = 0;
        r_alu = '0; r_srca = '0; r_srcb = '0; r_pcsrc = '0; r_rd = '0; r_m2r = '0;
        r_ext = 0; r_pcwr = 0; r_regwr = 0; r_memwe = 0; r_jmp = 0; r_addr_ok = 1;
        do begin
            mem_ready = !(state == 3'd3 && r_nmem < mem_waits);
            #1;
            case (state)
                3'd0: if (ir_wr && pc_wr) r_nir++;
                3'd1: if (pc_wr && pc_src == 2'b10) r_jmp = 1;
                3'd2: begin
                    r_alu = alu_ctrl; r_srca = alu_src_a; r_srcb = alu_src_b;
                    r_ext = ext; r_pcwr = pc_wr; r_pcsrc = pc_src;
                end
                3'd3: begin
                    r_nmem++;
                    if (mem_we) r_memwe = 1;
                    if (!mem_addr_sel || !mem_req) r_addr_ok = 0;
                end
                3'd4: begin r_regwr = reg_wr; r_rd = reg_dst; r_m2r = mem2reg; end
                default: ;
            endcase
            r_lat++;
            @(posedge clk); #1;
        end while (state != 3'd0 && r_lat < 12);
        mem_ready = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        vecs[0]  = '{6'h00, 6'h21, 1'b0, 4, 5'd0,  2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{6'h00, 6'h22, 1'b0, 4, 5'd1,  2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{6'h00, 6'h00, 1'b0, 4, 5'd2,  2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{6'h00, 6'h03, 1'b0, 4, 5'd9,  2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{6'h00, 6'h27, 1'b0, 4, 5'd10, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{6'h00, 6'h2b, 1'b0, 4, 5'd8,  2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{6'h09, 6'h00, 1'b0, 4, 5'd0,  2'd0, 2'd2, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{6'h0a, 6'h00, 1'b0, 4, 5'd4,  2'd0, 2'd2, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{6'h0d, 6'h00, 1'b0, 4, 5'd6,  2'd0, 2'd2, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{6'h0f, 6'h00, 1'b0, 4, 5'd2,  2'd1, 2'd2, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{6'h23, 6'h00, 1'b0, 5, 5'd0,  2'd0, 2'd2, 2'd0, 2'd0, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{6'h2b, 6'h00, 1'b0, 4, 5'd0,  2'd0, 2'd2, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{6'h04, 6'h00, 1'b1, 3, 5'd1,  2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{6'h04, 6'h00, 1'b0, 3, 5'd1,  2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{6'h05, 6'h00, 1'b0, 3, 5'd1,  2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{6'h05, 6'h00, 1'b1, 3, 5'd1,  2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{6'h02, 6'h00, 1'b0, 2, 5'd0,  2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        // Reset held with mem_ready high: everything must stay quiet.
        op = 6'h00; funct = 6'h21; mem_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", all_outs(), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("release_state", {29'd0, state}, 32'd0);
        chk("release_req", {30'd0, mem_req, mem_addr_sel}, 32'd2);

        foreach (vecs[i]) begin
            op = vecs[i].op; funct = vecs[i].funct; zero = vecs[i].zero;
            run_instr(0);
            chk($sformatf("v%0d_lat", i), r_lat, vecs[i].lat);
            chk($sformatf("v%0d_irwr", i), r_nir, 1);
            chk($sformatf("v%0d_alu", i), {r_alu, r_srca, r_srcb, r_ext},
                {vecs[i].alu, vecs[i].srca, vecs[i].srcb, vecs[i].ext});
            chk($sformatf("v%0d_pc", i), {r_pcwr, r_pcsrc, r_jmp},
                {vecs[i].pcwr, vecs[i].pcsrc, vecs[i].jmp});
            chk($sformatf("v%0d_wb", i), {r_regwr, r_rd, r_m2r, r_memwe},
                {vecs[i].regwr, vecs[i].rd, vecs[i].m2r, vecs[i].memwe});
        end

        // LW with two wait cycles in MEM.
        op = 6'h23; funct = 6'h00; zero = 1'b0;
        run_instr(2);
        chk("lw_wait_lat", r_lat, 7);
        chk("lw_wait_mem_cycles", r_nmem, 3);
        chk("lw_wait_mem_ctl", {r_memwe, r_addr_ok}, 2'b01);
        chk("lw_wait_wb", {r_regwr, r_m2r}, 3'b101);
        chk("lw_wait_no_timeout", {31'd0, timeout}, 32'd0);

        // Reset during WB must suppress reg_wr in that same cycle.
        op = 6'h00; funct = 6'h21;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_wb_state", {29'd0, state}, 32'd4);
        chk("mid_wb_regwr_pre", {31'd0, reg_wr}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_regwr", {31'd0, reg_wr}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("mid_rst_state_if", {29'd0, state, mem_req}, 32'd1);

        // Illegal opcode.
        op = 6'h3f; funct = 6'h00;
        @(posedge clk); #1;
        chk("ill_in_id", {29'd0, state}, 32'd1);
        @(posedge clk); #1;
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
        chk("ill_trap", {29'd0, state, illegal}, {29'd0, 3'd5, 1'b1});
        repeat (3) begin
            @(posedge clk); #1;
            chk("ill_trap_hold", {29'd0, state, mem_req}, {29'd0, 3'd5, 1'b0});
        end
`else
        chk("ill_nop", {29'd0, state, illegal}, 32'd0);
        chk("ill_nop_req", {31'd0, mem_req}, 32'd1);
`endif

        // Memory timeout in IF.
        do_reset();
        chk("to_flags_clear", {30'd0, illegal, timeout}, 32'd0);
        mem_ready = 1'b0;
        begin
            int n = 0;
            while (state == 3'd0 && n < 20) begin
                n++;
                @(posedge clk); #1;
            end
            chk("to_if_cycles", n, 4);
        end
        chk("to_trap", {29'd0, state, timeout}, {29'd0, 3'd5, 1'b1});
        mem_ready = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("to_hold", {28'd0, state, mem_req, pc_wr, ir_wr}, {28'd0, 3'd5, 3'b000});
        end
        chk("to_sticky", {31'd0, timeout}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
